// File: rtl/tli_spi_pkg.sv
// rtl/tli_spi_pkg.sv - shared types and constants for the TLI SPI responder
//
// Purpose: FSM state encoding, synchroniser depth and the default word sent
//          when the holding buffer is empty at frame start.
// Ports:   none (package).
package tli_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   localparam int SYNC_STAGES = 2;

   localparam logic [31:0] DEFAULT_IDLE_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/tli_spi_responder_if.sv
// rtl/tli_spi_responder_if.sv - fabric word source plus SPI pins of the responder
//
// Purpose: bundles the valid/ready word source and the SPI bus pins.
// Ports:   tx_data/tx_valid/tx_ready - word handshake into the responder
//          sck/ss_n                  - clock and frame select from the SPI master
//          miso/miso_oe              - serial data back to the master and its enable
// Modports: slave  - the responder
//           master - fabric source plus SPI master (driver side)
interface tli_spi_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic                  sck;
   logic                  ss_n;
   logic                  miso;
   logic                  miso_oe;

   modport master (
      output tx_data, tx_valid, sck, ss_n,
      input  tx_ready, miso, miso_oe
   );

   modport slave (
      input  tx_data, tx_valid, sck, ss_n,
      output tx_ready, miso, miso_oe
   );
endinterface

// File: rtl/tli_spi_sync_edge.sv
// rtl/tli_spi_sync_edge.sv - two-flop synchroniser with edge detection
//
// Purpose: brings an asynchronous pin into the clk domain and flags its edges.
// Ports:   clk, reset - system clock and synchronous active-high reset
//          pin_i      - asynchronous input
//          level_o    - synchronised level
//          rise_o     - one-cycle flag on a synchronised 0->1 transition
//          fall_o     - one-cycle flag on a synchronised 1->0 transition
module tli_spi_sync_edge
   import tli_spi_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         hist_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/tli_spi_responder.sv
// rtl/tli_spi_responder.sv - SPI device-side responder for the TLI sensor link
//
// Purpose: shifts one buffered DATA_WIDTH-bit word out on miso, MSB first, per
//          ss_n frame (CPHA=0); sends IDLE_WORD when nothing is buffered.
// Ports:   clk, reset  - system clock, synchronous active-high reset
//          bus (slave) - tx_data/tx_valid/tx_ready, sck, ss_n, miso, miso_oe
//          busy        - high while in SHIFT or DONE
//          frame_done  - pulse when all DATA_WIDTH bits have been sampled
//          frame_abort - pulse when ss_n rises before the frame completes
//          underrun    - pulse when IDLE_WORD is loaded from an empty buffer
module tli_spi_responder
   import tli_spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter bit                    CPOL       = 1'b0,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(DEFAULT_IDLE_WORD)
) (
   input  logic              clk,
   input  logic              reset,
   tli_spi_responder_if.slave bus,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort,
   output logic              underrun
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   typedef logic [CW-1:0] cnt_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   cnt_t                  cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  abort_q, abort_d;
   logic                  underrun_q, underrun_d;

   logic sck_rise, sck_fall, ss_rise, ss_fall;
   logic sck_level_unused, ss_level_unused;
   logic start, in_shift, last_bit, accept;

   // CPOL=1 is folded in ahead of the synchroniser so the internal clock
   // always idles low and rise is always the sampling edge.
   tli_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
      .clk     (clk),
      .reset   (reset),
      .pin_i   (bus.sck ^ CPOL),
      .level_o (sck_level_unused),
      .rise_o  (sck_rise),
      .fall_o  (sck_fall)
   );

   // ss_n history resets low: if the master already holds ss_n low when
   // reset releases, no false falling edge is seen; a later rise in IDLE is
   // harmless.
   tli_spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_ss (
      .clk     (clk),
      .reset   (reset),
      .pin_i   (bus.ss_n),
      .level_o (ss_level_unused),
      .rise_o  (ss_rise),
      .fall_o  (ss_fall)
   );

   assign start    = (state_q == ST_IDLE) && ss_fall;
   // ss_n rise wins over a coincident sck edge.
   assign in_shift = (state_q == ST_SHIFT) && !ss_rise;
   assign last_bit = (cnt_q == cnt_t'(DATA_WIDTH - 1));
   assign accept   = bus.tx_valid && !buf_full_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (ss_rise)                   state_d = ST_IDLE;
            else if (sck_rise && last_bit) state_d = ST_DONE;
         end
         ST_DONE:  if (ss_rise) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state
   always_comb begin
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
      if (accept) begin
         buf_d      = bus.tx_data;
         buf_full_d = 1'b1;
      end
      // accept and load are exclusive: one needs the buffer empty, the other full.
      if (start) begin
         cnt_d = '0;
         if (buf_full_q) begin
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
         end else begin
            shreg_d = IDLE_WORD;
         end
      end
      if (in_shift && sck_rise && (cnt_q != cnt_t'(DATA_WIDTH))) begin
         cnt_d = cnt_q + cnt_t'(1);
      end
      if (in_shift && sck_fall) begin
         shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign done_d     = in_shift && sck_rise && last_bit;
   assign abort_d    = (state_q == ST_SHIFT) && ss_rise;
   assign underrun_d = start && !buf_full_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shreg_q    <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         shreg_q    <= shreg_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
         underrun_q <= underrun_d;
      end
   end

   // Output logic
   always_comb begin
      busy         = (state_q != ST_IDLE);
      bus.miso_oe  = (state_q != ST_IDLE);
      bus.miso     = (state_q != ST_IDLE) ? shreg_q[DATA_WIDTH-1] : 1'b0;
      bus.tx_ready = !buf_full_q;
      frame_done   = done_q;
      frame_abort  = abort_q;
      underrun     = underrun_q;
   end

endmodule

// File: doc/tli_spi_responder.md
Name: tli_spi_responder

Overview:
- SPI device-side responder for the TLI sensor link. The existing TLI masters drive sck and ss_n and sample miso; this block is the far end.
- It takes 32-bit words from a fabric-side valid/ready source and shifts each one out on miso, MSB first, once per ss_n frame.
- Uses: sensor emulation, loopback testing of the TLI masters, and board-to-board links.
- All logic runs in the system clock domain. sck and ss_n are oversampled.

Parameters:
- DATA_WIDTH, 32: bits per frame and width of tx_data.
- CPOL, 0: sck idle level. CPOL=1 inverts sck internally before edge detection. CPHA is fixed at 0.
- IDLE_WORD, 32'hDEAD_BEEF: word shifted out when no data is buffered at frame start.

Ports:
- clk  in  1  system clock; sck frequency must be at most clk/8.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding buffer is empty; the word is accepted when tx_valid && tx_ready.
- sck  in  1  serial clock from the master; asynchronous.
- ss_n  in  1  active-low frame select from the master; asynchronous.
- miso  out  1  serial data to the master.
- miso_oe  out  1  output enable for the shared miso line.
- busy  out  1  high in SHIFT or DONE.
- frame_done  out  1  one-cycle pulse when all DATA_WIDTH bits have been sampled.
- frame_abort  out  1  one-cycle pulse when ss_n rises before the frame completes.
- underrun  out  1  one-cycle pulse when IDLE_WORD is loaded because the buffer was empty.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, busy=0, all pulse outputs 0, holding buffer empty, state IDLE, bit count 0.
- Reset takes priority over every other event.
- Input synchronisation:
  - sck and ss_n each pass through a 2-flop synchroniser plus one edge-history register.
  - An edge is flagged 3 clk after the pin changes.
- Holding buffer (one entry):
  - tx_ready = ~buf_full.
  - On accept, buf <= tx_data and buf_full <= 1.
  - Accepts are allowed in any state, including mid-frame.
- State IDLE (miso_oe=0):
  - On a synchronised ss_n falling edge, go to SHIFT and clear the bit count.
  - If buf_full: shreg <= buf and buf_full <= 0. tx_ready rises on the next cycle.
  - Else: shreg <= IDLE_WORD and underrun pulses.
  - miso_oe=1 and miso=shreg[MSB] from the next cycle onward.
  - The master must wait at least 4 clk after the ss_n fall before the first sck edge.
- State SHIFT, mode 0:
  - Each sampling (rising) edge increments the bit count.
  - Each shifting (falling) edge performs shreg <= shreg<<1, and miso follows the new MSB.
  - When the count reaches DATA_WIDTH on a sampling edge: frame_done pulses, go to DONE, and miso holds the last bit.
- State DONE:
  - sck edges are ignored.
  - On ss_n rising, go to IDLE with miso_oe=0 and miso=0.
  - No second word is sent within the same frame.
- ss_n rises in SHIFT with count < DATA_WIDTH:
  - frame_abort pulses and the state goes to IDLE.
  - The partially sent word is discarded, not restored to the buffer.
- Same-cycle sck and ss_n edges:
  - The ss_n edge is evaluated first.
  - An ss_n rise in SHIFT aborts the frame; the sck edge is ignored.
- ss_n low while coming out of reset: no frame starts until a genuine falling edge is seen.
- Bit counter width is $clog2(DATA_WIDTH+1). The counter saturates and does not wrap.

Decomposition:
- Package tli_spi_pkg:
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE}.
  - localparam SYNC_STAGES=2.
  - default IDLE_WORD constant.
- One sub-module, tli_spi_sync_edge:
  - 2-flop synchroniser plus edge detector, instantiated once each for sck and ss_n.
  - Outputs level, rise and fall, with sync reset.

Test Plan:
- Reset, then push 32'hA5A5_0F0F. Frame with sck = clk/8 and 32 pulses → master captures A5A50F0F, frame_done pulses once, tx_ready returns to 1, miso_oe drops after ss_n rises.
- No word pushed, then run a frame → underrun pulses, master captures DEADBEEF.
- Push 32'h1234_5678, then raise ss_n after 10 sck pulses → frame_abort pulses. The next frame with 32'hCAFE_F00D pushed captures CAFEF00D.
- Push a second word 32'h0000_0001 mid-frame → accepted (tx_ready 1→0). The current frame is unaffected; the following frame captures 00000001.
- CPOL=1 build with idle-high sck, word 32'h8000_0001 → captured correctly. frame_done fires on the 32nd rising edge of the inverted clock.
- Assert reset mid-frame at bit 17 → all outputs return to reset values next cycle, no pulses occur, buffer is empty (tx_ready=1).
